// File: rtl/systolic_psum_collector.sv
// systolic_psum_collector: deskews skewed PE column psums into rows, saturates them, buffers and frames them per tile
module systolic_psum_collector #(
  parameter int UNIT_NUM   = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0,
  parameter int TILE_ROWS  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              s_clk,
  input  logic                              s_rst,
  input  logic [UNIT_NUM-1:0]               psum_valid,
  input  logic [UNIT_NUM*PSUM_WIDTH-1:0]    psum_data,
  input  logic                              err_clr,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [UNIT_NUM*OUT_WIDTH-1:0]     m_data,
  output logic                              m_last,
  output logic                              overflow,
  output logic                              align_err,
  output logic                              busy
);
  localparam int PW = PSUM_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int DW = UNIT_NUM * OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = TILE_ROWS > 1 ? $clog2(TILE_ROWS) : 1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [UNIT_NUM-1:0] dv, dbusy;
  logic [PW-1:0]       dd [UNIT_NUM];
  logic [DW-1:0]       sat_w;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sat_v_q, sat_l_q;
  logic [DW-1:0]       sat_d_q;
  logic [DW:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, rp_q;
  logic [AW:0]         n_q, n_d;
  logic                ovf_q, ovf_d, aerr_q, aerr_d;
  logic                aligned, partial, last, full, rd, wr, drop;

  genvar c;
  for (c = 0; c < UNIT_NUM; c++) begin : g_col
    logic signed [PW-1:0] sh;
    if (c == UNIT_NUM-1) begin : g_direct
      assign dv[c]    = psum_valid[c];
      assign dd[c]    = psum_data[c*PW +: PW];
      assign dbusy[c] = 1'b0;
    end else begin : g_dly
      localparam int D = UNIT_NUM-1-c;
      logic [D-1:0]  v_q;
      logic [PW-1:0] d_q [D];
      // delay column c so it lines up with the last column
      always_ff @(posedge s_clk or posedge s_rst)
        if (s_rst) begin
          v_q <= '0;
          for (int k = 0; k < D; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= psum_valid[c];
          d_q[0] <= psum_data[c*PW +: PW];
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      assign dv[c]    = v_q[D-1];
      assign dd[c]    = d_q[D-1];
      assign dbusy[c] = |v_q;
    end
    assign sh = $signed(dd[c]) >>> SHIFT;
    assign sat_w[c*OW +: OW] = sh > MAXV ? MAXV[OW-1:0] : sh < MINV ? MINV[OW-1:0] : sh[OW-1:0];
  end

  assign aligned = &dv;
  assign partial = |dv & ~aligned;
  assign last    = cnt_q == CW'(TILE_ROWS-1);
  assign full    = n_q == (AW+1)'(FIFO_DEPTH);
  assign m_valid = n_q != '0;
  assign rd      = m_valid & m_ready;
  assign wr      = sat_v_q & (~full | rd);
  assign drop    = sat_v_q & full & ~rd;
  assign m_data    = m_valid ? mem[rp_q][DW-1:0] : '0;
  assign m_last    = m_valid & mem[rp_q][DW];
  assign overflow  = ovf_q;
  assign align_err = aerr_q;
  assign busy      = |dbusy | sat_v_q | m_valid;

  // next-state for row counter, fifo occupancy and sticky flags
  always_comb begin
    cnt_d  = aligned ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    n_d    = n_q + (AW+1)'(wr) - (AW+1)'(rd);
    ovf_d  = drop | (ovf_q & ~err_clr);
    aerr_d = partial | (aerr_q & ~err_clr);
  end

  // sat stage, framing counter, fifo pointers and flags
  always_ff @(posedge s_clk or posedge s_rst)
    if (s_rst) begin
      sat_v_q <= 1'b0;
      sat_l_q <= 1'b0;
      sat_d_q <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      sat_v_q <= aligned;
      sat_l_q <= last;
      sat_d_q <= sat_w;
      cnt_q   <= cnt_d;
      wp_q    <= wr ? wp_q + 1'b1 : wp_q;
      rp_q    <= rd ? rp_q + 1'b1 : rp_q;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      aerr_q  <= aerr_d;
    end

  // row storage carries the tile-last flag alongside the data
  always_ff @(posedge s_clk)
    if (wr) mem[wp_q] <= {sat_l_q, sat_d_q};
endmodule
